// File: rtl/risc_alu_pkg.sv
// Shared opcode encodings for the accumulator-style RISC core ALU.
package risc_alu_pkg;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_HLT = 3'b000;
  localparam opcode_t OP_SKZ = 3'b001;
  localparam opcode_t OP_ADD = 3'b010;
  localparam opcode_t OP_AND = 3'b011;
  localparam opcode_t OP_XOR = 3'b100;
  localparam opcode_t OP_LDA = 3'b101;
  localparam opcode_t OP_STO = 3'b110;
  localparam opcode_t OP_JMP = 3'b111;

endpackage

// File: rtl/risc_alu_core.sv
// Combinational ALU function: result, accumulator zero flag and, with
// RISC_ALU_CARRY_EN defined, the ADD carry.
module risc_alu_core
  import risc_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  opcode_t            opcode,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic [WIDTH-1:0]   result,
  output logic               a_zero
`ifdef RISC_ALU_CARRY_EN
  ,
  output logic               carry
`endif
);

`ifdef RISC_ALU_CARRY_EN
  logic [WIDTH:0] sum;
  assign sum = {1'b0, in_a} + {1'b0, in_b};
`else
  logic [WIDTH-1:0] sum;
  assign sum = in_a + in_b;
`endif

  assign a_zero = (in_a == '0);

  always_comb begin
    // NOTE: every output of this block is assigned before the case so no path
    // leaves it holding its old value, which would infer a latch.
    result = in_a;
`ifdef RISC_ALU_CARRY_EN
    carry  = 1'b0;
`endif
    case (opcode)
      OP_ADD: begin
        result = sum[WIDTH-1:0];
`ifdef RISC_ALU_CARRY_EN
        carry  = sum[WIDTH];
`endif
      end
      OP_AND:  result = in_a & in_b;
      OP_XOR:  result = in_a ^ in_b;
      OP_LDA:  result = in_b;
      default: ;  // HLT, SKZ, STO, JMP pass the accumulator through
    endcase
  end

endmodule

// File: rtl/risc_alu.sv
// Registered RISC ALU: one-cycle result and zero flag with async reset.
// Optional carry_out port is enabled by defining RISC_ALU_CARRY_EN.
module risc_alu
  import risc_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] alu_out,
  output logic             a_is_zero
`ifdef RISC_ALU_CARRY_EN
  ,
  output logic             carry_out
`endif
);

  logic [WIDTH-1:0] result;
  logic             a_zero;
`ifdef RISC_ALU_CARRY_EN
  logic             carry;
`endif

  risc_alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .opcode (opcode_t'(opcode)),
    .in_a   (in_a),
    .in_b   (in_b),
    .result (result),
    .a_zero (a_zero)
`ifdef RISC_ALU_CARRY_EN
    ,
    .carry  (carry)
`endif
  );

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_out   <= '0;
      a_is_zero <= 1'b0;
    end else begin
      alu_out   <= result;
      a_is_zero <= a_zero;
    end
  end

`ifdef RISC_ALU_CARRY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) carry_out <= 1'b0;
    else     carry_out <= carry;
  end
`endif

endmodule

// File: tb/tb_risc_alu.sv
// Scoreboard bench for risc_alu: the driver queues expected results, a
// monitor compares them one edge later. Define RISC_ALU_CARRY_EN to cover carry_out.
module tb_risc_alu;

  localparam int WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             carry;
    string            name;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [2:0]       opcode = 3'b000;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic [WIDTH-1:0] alu_out;
  logic             a_is_zero;
`ifdef RISC_ALU_CARRY_EN
  logic             carry_out;
`endif

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  risc_alu #(
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .in_a      (in_a),
    .in_b      (in_b),
    .alu_out   (alu_out),
    .a_is_zero (a_is_zero)
`ifdef RISC_ALU_CARRY_EN
    ,
    .carry_out (carry_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model written straight from the opcode table.
  function automatic exp_t model(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input string name);
    exp_t e;
    logic [WIDTH:0] s;
    s       = {1'b0, a} + {1'b0, b};
    e.name  = name;
    e.zero  = (a == '0);
    e.carry = 1'b0;
    unique case (op)
      3'b010: begin e.res = s[WIDTH-1:0]; e.carry = s[WIDTH]; end
      3'b011: e.res = a & b;
      3'b100: e.res = a ^ b;
      3'b101: e.res = b;
      default: e.res = a;
    endcase
    return e;
  endfunction

  function automatic exp_t mk(input logic [WIDTH-1:0] r, input logic z, input logic c,
                              input string name);
    exp_t e;
    e.res = r; e.zero = z; e.carry = c; e.name = name;
    return e;
  endfunction

  task automatic drive(input logic [2:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input exp_t e);
    @(negedge clk);
    opcode = op;
    in_a   = a;
    in_b   = b;
    exp_q.push_back(e);
  endtask

  // Monitor: the DUT presents a new result every cycle, so each queued
  // expectation is consumed just after the following rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, ".alu_out"}, 32'(alu_out), 32'(e.res));
        check({e.name, ".a_is_zero"}, 32'(a_is_zero), 32'(e.zero));
`ifdef RISC_ALU_CARRY_EN
        check({e.name, ".carry_out"}, 32'(carry_out), 32'(e.carry));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]       op;
    logic [WIDTH-1:0] a, b;
    int               wait_cycles;

    // Reset asserted before any clock edge must clear outputs at once.
    opcode = 3'b010; in_a = 8'h00; in_b = 8'h55;
    #2 rst = 1'b1;
    #1;
    check("rst_imm.alu_out", 32'(alu_out), 32'h0);
    check("rst_imm.a_is_zero", 32'(a_is_zero), 32'h0);
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_hold.alu_out", 32'(alu_out), 32'h0);
      check("rst_hold.a_is_zero", 32'(a_is_zero), 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(mk(8'h55, 1'b1, 1'b0, "rst_release"));

    // Every opcode with the same operands.
    drive(3'b000, 8'h3C, 8'hA5, mk(8'h3C, 1'b0, 1'b0, "op_hlt"));
    drive(3'b001, 8'h3C, 8'hA5, mk(8'h3C, 1'b0, 1'b0, "op_skz"));
    drive(3'b010, 8'h3C, 8'hA5, mk(8'hE1, 1'b0, 1'b0, "op_add"));
    drive(3'b011, 8'h3C, 8'hA5, mk(8'h24, 1'b0, 1'b0, "op_and"));
    drive(3'b100, 8'h3C, 8'hA5, mk(8'h99, 1'b0, 1'b0, "op_xor"));
    drive(3'b101, 8'h3C, 8'hA5, mk(8'hA5, 1'b0, 1'b0, "op_lda"));
    drive(3'b110, 8'h3C, 8'hA5, mk(8'h3C, 1'b0, 1'b0, "op_sto"));
    drive(3'b111, 8'h3C, 8'hA5, mk(8'h3C, 1'b0, 1'b0, "op_jmp"));

    // ADD wrap-around and carry boundary.
    drive(3'b010, 8'hFF, 8'h01, mk(8'h00, 1'b0, 1'b1, "add_wrap"));
    drive(3'b010, 8'h7F, 8'h01, mk(8'h80, 1'b0, 1'b0, "add_7f"));

    // Zero flag follows in_a only.
    drive(3'b101, 8'h00, 8'hFF, mk(8'hFF, 1'b1, 1'b0, "zero_lda"));
    drive(3'b100, 8'h00, 8'hFF, mk(8'hFF, 1'b1, 1'b0, "zero_xor"));

    // Async reset pulse between edges discards the held result.
    drive(3'b010, 8'h10, 8'h20, mk(8'h30, 1'b0, 1'b0, "pre_pulse"));
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("pulse.alu_out", 32'(alu_out), 32'h0);
    check("pulse.a_is_zero", 32'(a_is_zero), 32'h0);
    #1 rst = 1'b0;
    drive(3'b010, 8'h10, 8'h20, mk(8'h30, 1'b0, 1'b0, "post_pulse"));

    // Random traffic against the reference model.
    for (int i = 0; i < 1000; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = 8'($urandom);
      b  = 8'($urandom);
      if (i % 16 == 0) a = 8'h00;
      drive(op, a, b, model(op, a, b, "rand"));
    end

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/risc_alu.md
Name: risc_alu

Overview:
- Datapath ALU of the small accumulator-style RISC core.
- Takes a 3-bit instruction opcode, the accumulator operand in_a and the memory operand in_b.
- Produces the result that is written back to the accumulator, plus a zero flag on in_a that the SKZ instruction uses.
- Both outputs are registered on the core clock.

Parameters:
- WIDTH, 8, data width of in_a, in_b and alu_out; any value of 1 or more is legal.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- opcode  input  3  instruction opcode.
- in_a  input  WIDTH  accumulator operand.
- in_b  input  WIDTH  memory/data operand.
- alu_out  output  WIDTH  registered result.
- a_is_zero  output  1  registered flag, 1 when in_a equals 0.
- Interface rule: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset: rst high clears alu_out to 0 and a_is_zero to 0 immediately, without waiting for a clock edge. Both hold while rst is high. The first capture happens on the first rising clk edge after rst is deasserted.
- Latency is 1 cycle. At each rising edge, alu_out takes f(opcode, in_a, in_b) and a_is_zero takes (in_a == 0), both from the inputs sampled at that edge. There is no enable, so the outputs update every cycle.
- Opcode map, result f:
  - 000 HLT: in_a
  - 001 SKZ: in_a
  - 010 ADD: in_a + in_b, truncated to WIDTH bits (modulo 2^WIDTH, carry discarded)
  - 011 AND: in_a & in_b
  - 100 XOR: in_a ^ in_b
  - 101 LDA: in_b
  - 110 STO: in_a
  - 111 JMP: in_a
- All 8 opcodes are defined, so there is no illegal-opcode case. X on opcode propagates as X; no special handling is required.
- a_is_zero depends only on in_a, never on opcode or on the result.
- ADD wrap-around: for WIDTH=8, 0xFF + 0x01 gives 0x00. Overflow has no side effect unless the optional feature below is compiled in.
- If rst is asserted mid-operation, any pending result is discarded.
- Outputs are pure flops and have no combinational path from the inputs.

Optional Feature:
- Macro RISC_ALU_CARRY_EN.
- When defined:
  - Adds output port carry_out (1 bit), registered alongside alu_out.
  - For ADD it equals bit WIDTH of the (WIDTH+1)-bit sum in_a + in_b.
  - For every other opcode it is 0.
  - Reset value is 0.
- When undefined: the port does not exist and behaviour is otherwise identical.

Decomposition:
- Package risc_alu_pkg holds:
  - the opcode constants OP_HLT=3'b000, OP_SKZ=3'b001, OP_ADD=3'b010, OP_AND=3'b011, OP_XOR=3'b100, OP_LDA=3'b101, OP_STO=3'b110, OP_JMP=3'b111;
  - a 3-bit opcode typedef.
- One natural sub-module, risc_alu_core: purely combinational result, zero-flag and carry computation. The top level adds the output register stage and the async reset.

Test Plan:
- Reset: assert rst with in_a=0x00, in_b=0x55, opcode=010 -> alu_out=0x00 and a_is_zero=0 immediately, and they stay so across clock edges. Deassert rst; after one edge -> alu_out=0x55, a_is_zero=1.
- Each opcode with in_a=0x3C, in_b=0xA5, sampled one edge later:
  - 000, 001, 110, 111 -> 0x3C
  - 010 -> 0xE1
  - 011 -> 0x24
  - 100 -> 0x99
  - 101 -> 0xA5
  - a_is_zero=0 throughout.
- ADD wrap: in_a=0xFF, in_b=0x01, opcode=010 -> alu_out=0x00, a_is_zero=0. With RISC_ALU_CARRY_EN, carry_out=1. With in_a=0x7F, in_b=0x01 -> 0x80, carry_out=0.
- Zero flag independent of opcode: in_a=0x00, in_b=0xFF, opcode=101 -> alu_out=0xFF, a_is_zero=1. Then opcode=100 -> alu_out=0xFF, a_is_zero=1.
- Async reset mid-stream: opcode=010, in_a=0x10, in_b=0x20 gives alu_out=0x30. Pulse rst between edges -> alu_out falls to 0x00 before the next edge.
- Randomized: 1000 cycles of random opcode, in_a and in_b, checked each cycle against the opcode map delayed by one cycle.
